// File: rtl/trav_stack.sv
// Per-ray kd-tree traversal stack: push far children, pop next node, overflow-aware empty responses.
// Optional statistics counters are enabled by defining TRAV_STACK_STATS_EN.
module trav_stack #(
    parameter int unsigned NUM_RAYS = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned NODE_W   = 16,
    parameter int unsigned FLOAT_W  = 32,
    localparam int unsigned RW      = $clog2(NUM_RAYS),
    localparam int unsigned DW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
`ifdef TRAV_STACK_STATS_EN
    output logic [31:0]        stat_push_cnt,
    output logic [31:0]        stat_pop_cnt,
    output logic [31:0]        stat_drop_cnt,
`endif
    input  logic               push_valid,
    input  logic [RW-1:0]      push_ray_id,
    input  logic [NODE_W-1:0]  push_node,
    input  logic [FLOAT_W-1:0] push_t_min,
    input  logic [FLOAT_W-1:0] push_t_max,
    input  logic               pop_valid,
    input  logic [RW-1:0]      pop_ray_id,
    output logic               pop_ready,
    input  logic               clear_valid,
    input  logic [RW-1:0]      clear_ray_id,
    output logic               resp_valid,
    output logic [RW-1:0]      resp_ray_id,
    output logic               resp_empty,
    output logic               resp_restart,
    output logic [NODE_W-1:0]  resp_node,
    output logic [FLOAT_W-1:0] resp_t_min,
    output logic [FLOAT_W-1:0] resp_t_max,
    input  logic               resp_stall
);
    localparam int unsigned CW      = DW + 1;
    localparam int unsigned AW      = RW + DW;
    localparam int unsigned ENTRIES = NUM_RAYS * DEPTH;
    localparam int unsigned EW      = NODE_W + 2 * FLOAT_W;

    logic [EW-1:0] mem [ENTRIES];

    logic [DW-1:0] top_q [NUM_RAYS];
    logic [DW-1:0] top_d [NUM_RAYS];
    logic [CW-1:0] cnt_q [NUM_RAYS];
    logic [CW-1:0] cnt_d [NUM_RAYS];
    logic          ovf_q [NUM_RAYS];
    logic          ovf_d [NUM_RAYS];

    logic          stall_hold;
    logic          push_do;
    logic          push_full;
    logic          pop_do;
    logic          pop_is_empty;
    logic [DW-1:0] rd_top;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [EW-1:0] rd_entry;

    assign stall_hold = resp_valid && resp_stall;
    assign pop_ready  = !stall_hold
                        && !(push_valid && push_ray_id == pop_ray_id)
                        && !(clear_valid && clear_ray_id == pop_ray_id);

    // A clear to the same ray discards the push entirely.
    assign push_do      = push_valid && !(clear_valid && clear_ray_id == push_ray_id);
    assign push_full    = cnt_q[push_ray_id] == CW'(DEPTH);
    assign pop_do       = pop_valid && pop_ready;
    assign pop_is_empty = cnt_q[pop_ray_id] == '0;
    assign rd_top       = top_q[pop_ray_id] - DW'(1);
    assign wr_addr      = {push_ray_id, top_q[push_ray_id]};
    assign rd_addr      = {pop_ray_id, rd_top};
    assign rd_entry     = mem[rd_addr];

    always_comb begin
        for (int unsigned r = 0; r < NUM_RAYS; r++) begin
            top_d[r] = top_q[r];
            cnt_d[r] = cnt_q[r];
            ovf_d[r] = ovf_q[r];
            if (clear_valid && clear_ray_id == RW'(r)) begin
                cnt_d[r] = '0;
                ovf_d[r] = 1'b0;
            end else if (push_do && push_ray_id == RW'(r)) begin
                top_d[r] = top_q[r] + DW'(1);
                if (cnt_q[r] == CW'(DEPTH)) begin
                    ovf_d[r] = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] + CW'(1);
                end
            end else if (pop_do && pop_ray_id == RW'(r) && cnt_q[r] != '0) begin
                top_d[r] = top_q[r] - DW'(1);
                cnt_d[r] = cnt_q[r] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_do) begin
            mem[wr_addr] <= {push_node, push_t_min, push_t_max};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_RAYS; r++) begin
                top_q[r] <= '0;
                cnt_q[r] <= '0;
                ovf_q[r] <= 1'b0;
            end
            resp_valid   <= 1'b0;
            resp_empty   <= 1'b0;
            resp_restart <= 1'b0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (!stall_hold) begin
                resp_valid <= pop_do;
                if (pop_do) begin
                    resp_empty   <= pop_is_empty;
                    resp_restart <= pop_is_empty && ovf_q[pop_ray_id];
                end
            end
        end
    end

    // Payload is don't-care when empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!stall_hold && pop_do) begin
            resp_ray_id                         <= pop_ray_id;
            {resp_node, resp_t_min, resp_t_max} <= rd_entry;
        end
    end

`ifdef TRAV_STACK_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_push_cnt <= '0;
            stat_pop_cnt  <= '0;
            stat_drop_cnt <= '0;
        end else begin
            if (push_do && stat_push_cnt != '1) begin
                stat_push_cnt <= stat_push_cnt + 32'd1;
            end
            if (pop_do && !pop_is_empty && stat_pop_cnt != '1) begin
                stat_pop_cnt <= stat_pop_cnt + 32'd1;
            end
            if (push_do && push_full && stat_drop_cnt != '1) begin
                stat_drop_cnt <= stat_drop_cnt + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_trav_stack.sv
// Scoreboard bench for trav_stack: stimulus queues expected pop responses, a monitor checks them.
module tb_trav_stack;
    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid;
    logic [2:0]  push_ray_id;
    logic [15:0] push_node;
    logic [31:0] push_t_min;
    logic [31:0] push_t_max;
    logic        pop_valid;
    logic [2:0]  pop_ray_id;
    logic        pop_ready;
    logic        clear_valid;
    logic [2:0]  clear_ray_id;
    logic        resp_valid;
    logic [2:0]  resp_ray_id;
    logic        resp_empty;
    logic        resp_restart;
    logic [15:0] resp_node;
    logic [31:0] resp_t_min;
    logic [31:0] resp_t_max;
    logic        resp_stall;
`ifdef TRAV_STACK_STATS_EN
    logic [31:0] stat_push_cnt;
    logic [31:0] stat_pop_cnt;
    logic [31:0] stat_drop_cnt;
`endif

    trav_stack dut (
        .clk          (clk),
        .rst          (rst),
`ifdef TRAV_STACK_STATS_EN
        .stat_push_cnt(stat_push_cnt),
        .stat_pop_cnt (stat_pop_cnt),
        .stat_drop_cnt(stat_drop_cnt),
`endif
        .push_valid   (push_valid),
        .push_ray_id  (push_ray_id),
        .push_node    (push_node),
        .push_t_min   (push_t_min),
        .push_t_max   (push_t_max),
        .pop_valid    (pop_valid),
        .pop_ray_id   (pop_ray_id),
        .pop_ready    (pop_ready),
        .clear_valid  (clear_valid),
        .clear_ray_id (clear_ray_id),
        .resp_valid   (resp_valid),
        .resp_ray_id  (resp_ray_id),
        .resp_empty   (resp_empty),
        .resp_restart (resp_restart),
        .resp_node    (resp_node),
        .resp_t_min   (resp_t_min),
        .resp_t_max   (resp_t_max),
        .resp_stall   (resp_stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  ray;
        logic        empty;
        logic        restart;
        logic [15:0] node;
        logic [31:0] tmin;
        logic [31:0] tmax;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total  = 0;
    int   passed = 0;

    function automatic logic [31:0] fmin(input logic [15:0] n);
        return 32'h3f80_0000 + {16'h0, n};
    endfunction

    function automatic logic [31:0] fmax(input logic [15:0] n);
        return 32'h4100_0000 + {16'h0, n};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [2:0] ray, input logic [15:0] node);
        push_valid  = 1'b1;
        push_ray_id = ray;
        push_node   = node;
        push_t_min  = fmin(node);
        push_t_max  = fmax(node);
        cyc();
        push_valid  = 1'b0;
    endtask

    task automatic do_clear(input logic [2:0] ray);
        clear_valid  = 1'b1;
        clear_ray_id = ray;
        cyc();
        clear_valid  = 1'b0;
    endtask

    task automatic expect_resp(input logic [2:0] ray, input logic empty, input logic restart,
                               input logic [15:0] node);
        exp_t e;
        e.ray     = ray;
        e.empty   = empty;
        e.restart = restart;
        e.node    = node;
        e.tmin    = fmin(node);
        e.tmax    = fmax(node);
        sb.push_back(e);
    endtask

    task automatic do_pop(input string name, input logic [2:0] ray, input logic empty,
                          input logic restart, input logic [15:0] node);
        pop_valid  = 1'b1;
        pop_ray_id = ray;
        #1;
        chk({name, "_ready"}, {63'h0, pop_ready}, 64'h1);
        expect_resp(ray, empty, restart, node);
        cyc();
        pop_valid = 1'b0;
    endtask

    // Consumes a response only on a non-stalled cycle, so each one is checked once.
    always @(negedge clk) begin
        if (!rst && resp_valid && !resp_stall) begin
            total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_resp: got ray=%0d node=%0h empty=%0b, expected none",
                         resp_ray_id, resp_node, resp_empty);
            end else begin
                mon_e = sb.pop_front();
                if (resp_ray_id == mon_e.ray && resp_empty == mon_e.empty
                    && resp_restart == mon_e.restart
                    && (mon_e.empty || (resp_node == mon_e.node && resp_t_min == mon_e.tmin
                                        && resp_t_max == mon_e.tmax))) begin
                    passed++;
                end else begin
                    $display("FAIL resp: got ray=%0d empty=%0b restart=%0b node=%0h tmin=%0h tmax=%0h, expected ray=%0d empty=%0b restart=%0b node=%0h tmin=%0h tmax=%0h",
                             resp_ray_id, resp_empty, resp_restart, resp_node, resp_t_min,
                             resp_t_max, mon_e.ray, mon_e.empty, mon_e.restart, mon_e.node,
                             mon_e.tmin, mon_e.tmax);
                end
            end
        end
    end

    initial begin
        rst          = 1'b1;
        push_valid   = 1'b0;
        push_ray_id  = '0;
        push_node    = '0;
        push_t_min   = '0;
        push_t_max   = '0;
        pop_valid    = 1'b0;
        pop_ray_id   = '0;
        clear_valid  = 1'b0;
        clear_ray_id = '0;
        resp_stall   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_resp_valid", {63'h0, resp_valid}, 64'h0);
        chk("rst_resp_empty", {63'h0, resp_empty}, 64'h0);
        chk("rst_resp_restart", {63'h0, resp_restart}, 64'h0);
        chk("rst_pop_ready", {63'h0, pop_ready}, 64'h1);
        do_pop("rst_pop", 3'd0, 1'b1, 1'b0, 16'h0);

        // LIFO order on ray 2
        do_push(3'd2, 16'd5);
        do_push(3'd2, 16'd6);
        do_push(3'd2, 16'd7);
        do_pop("lifo7", 3'd2, 1'b0, 1'b0, 16'd7);
        do_pop("lifo6", 3'd2, 1'b0, 1'b0, 16'd6);
        do_pop("lifo5", 3'd2, 1'b0, 1'b0, 16'd5);
        do_pop("lifo_empty", 3'd2, 1'b1, 1'b0, 16'h0);

        // Overflow on ray 0: 1 and 2 are overwritten
        for (int n = 1; n <= 6; n++) do_push(3'd0, 16'(n));
        do_pop("ovf6", 3'd0, 1'b0, 1'b0, 16'd6);
        do_pop("ovf5", 3'd0, 1'b0, 1'b0, 16'd5);
        do_pop("ovf4", 3'd0, 1'b0, 1'b0, 16'd4);
        do_pop("ovf3", 3'd0, 1'b0, 1'b0, 16'd3);
        do_pop("ovf_restart", 3'd0, 1'b1, 1'b1, 16'h0);
        do_clear(3'd0);
        do_pop("clr_empty", 3'd0, 1'b1, 1'b0, 16'h0);

        // Push/pop conflict on ray 1
        push_valid  = 1'b1;
        push_ray_id = 3'd1;
        push_node   = 16'd9;
        push_t_min  = fmin(16'd9);
        push_t_max  = fmax(16'd9);
        pop_valid   = 1'b1;
        pop_ray_id  = 3'd1;
        #1;
        chk("conflict_ready", {63'h0, pop_ready}, 64'h0);
        cyc();
        push_valid = 1'b0;
        do_pop("retry9", 3'd1, 1'b0, 1'b0, 16'd9);

        // Stall hold on ray 4
        do_push(3'd4, 16'd11);
        do_push(3'd4, 16'd12);
        pop_valid  = 1'b1;
        pop_ray_id = 3'd4;
        #1;
        chk("stall_pop_ready", {63'h0, pop_ready}, 64'h1);
        expect_resp(3'd4, 1'b0, 1'b0, 16'd12);
        cyc();
        resp_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_ready", {63'h0, pop_ready}, 64'h0);
            chk("stall_valid", {63'h0, resp_valid}, 64'h1);
            chk("stall_node", {48'h0, resp_node}, 64'd12);
            chk("stall_tmin", {32'h0, resp_t_min}, {32'h0, fmin(16'd12)});
            cyc();
        end
        resp_stall = 1'b0;
        #1;
        chk("unstall_ready", {63'h0, pop_ready}, 64'h1);
        expect_resp(3'd4, 1'b0, 1'b0, 16'd11);
        cyc();
        pop_valid = 1'b0;

        // Interleave: push A on ray 0 while popping B from ray 3
        do_push(3'd3, 16'd20);
        push_valid  = 1'b1;
        push_ray_id = 3'd0;
        push_node   = 16'd21;
        push_t_min  = fmin(16'd21);
        push_t_max  = fmax(16'd21);
        pop_valid   = 1'b1;
        pop_ray_id  = 3'd3;
        #1;
        chk("inter_ready", {63'h0, pop_ready}, 64'h1);
        expect_resp(3'd3, 1'b0, 1'b0, 16'd20);
        cyc();
        push_valid = 1'b0;
        pop_valid  = 1'b0;
        do_pop("inter_a", 3'd0, 1'b0, 1'b0, 16'd21);

        // Let outstanding responses drain before the reset test
        for (int i = 0; i < 10 && sb.size() != 0; i++) cyc();
        chk("drain_before_rst", 64'(sb.size()), 64'h0);

        // Reset with a pending, stalled response on ray 5
        do_push(3'd5, 16'd30);
        do_push(3'd5, 16'd31);
        pop_valid  = 1'b1;
        pop_ray_id = 3'd5;
        cyc();
        pop_valid  = 1'b0;
        resp_stall = 1'b1;
        #1;
        chk("pending_valid", {63'h0, resp_valid}, 64'h1);
        rst = 1'b1;
        cyc();
        rst        = 1'b0;
        resp_stall = 1'b0;
        #1;
        chk("post_rst_valid", {63'h0, resp_valid}, 64'h0);
        chk("post_rst_ready", {63'h0, pop_ready}, 64'h1);
        do_pop("post_rst5", 3'd5, 1'b1, 1'b0, 16'h0);
        do_pop("post_rst0", 3'd0, 1'b1, 1'b0, 16'h0);
        do_pop("post_rst4", 3'd4, 1'b1, 1'b0, 16'h0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) cyc();
        chk("drain_final", 64'(sb.size()), 64'h0);
        repeat (2) cyc();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
